// File: rtl/sobel_gradient_stage.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_gradient_stage
//  Purpose  : Sliding 3x3 window over column triplets from the double line
//             buffer; computes the Sobel magnitude |Gx|+|Gy| saturated to
//             8 bits in a 3-stage pipeline with valid tracking, per-row edge
//             suppression and a frame-done pulse.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1  rising-edge clock
//    rst      in   1  asynchronous active-low reset
//    valid_i  in   1  column triplet valid (line buffer write enable)
//    data0_i  in   8  pixel from row y-2 (oldest)
//    data1_i  in   8  pixel from row y-1
//    data2_i  in   8  pixel from row y (newest)
//    valid_o  out  1  data_o holds a gradient pixel
//    data_o   out  8  saturated gradient magnitude (or binary 0/255)
//    done_o   out  1  one-cycle pulse with the last output pixel of a frame
//  Configuration
//    SOBEL_THRESHOLD_EN  when defined, data_o is 255 if the saturated
//                        magnitude >= THRESHOLD, otherwise 0.
// ============================================================================
module sobel_gradient_stage #(
  parameter int         IMG_WIDTH  = 5,
  parameter int         IMG_HEIGHT = 5,
  parameter logic [7:0] THRESHOLD  = 8'd64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_i,
  input  logic [7:0] data0_i,
  input  logic [7:0] data1_i,
  input  logic [7:0] data2_i,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       done_o
);

  localparam int                COL_W     = $clog2(IMG_WIDTH);
  localparam int                ROW_W     = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0]  COL_FIRST = COL_W'(2);
  // Only IMG_HEIGHT-2 triplet rows exist per frame: the first two image rows
  // are consumed filling the line buffer.
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_HEIGHT - 3);

  // --------------------------------------------------------------------------
  // Stage 1: window, counters, complete/last flags
  // --------------------------------------------------------------------------
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [7:0]       win [3][3];   // win[row][col], col 2 is newest
  logic             s1_valid;
  logic             s1_last;
  logic             col_wrap;
  logic             frame_end;

  assign col_wrap  = (col == COL_LAST);
  assign frame_end = col_wrap && (row == ROW_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col      <= '0;
      row      <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= 8'd0;
        end
      end
    end else begin
      // Columns 0 and 1 of a row only prime the window, so no window ever
      // straddles two rows.
      s1_valid <= valid_i && (col >= COL_FIRST);
      s1_last  <= valid_i && frame_end;
      if (valid_i) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= data0_i;
        win[1][2] <= data1_i;
        win[2][2] <= data2_i;
        if (col_wrap) begin
          col <= '0;
          row <= frame_end ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  // 1-2-1 weighted sum of three pixels; max 1020, fits 11 bits.
  function automatic logic [10:0] wsum(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic [7:0] c);
    return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
  endfunction

  logic [10:0] gx_comb;
  logic [10:0] gy_comb;

  // Gx: right column minus left column. Gy: bottom row minus top row.
  assign gx_comb = wsum(win[0][2], win[1][2], win[2][2])
                 - wsum(win[0][0], win[1][0], win[2][0]);
  assign gy_comb = wsum(win[2][0], win[2][1], win[2][2])
                 - wsum(win[0][0], win[0][1], win[0][2]);

  // --------------------------------------------------------------------------
  // Stage 2: registered gradients (two's complement, range +/-1020)
  // --------------------------------------------------------------------------
  logic [10:0] gx;
  logic [10:0] gy;
  logic        s2_valid;
  logic        s2_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gx       <= 11'd0;
      gy       <= 11'd0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
    end else begin
      gx       <= gx_comb;
      gy       <= gy_comb;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: magnitude, saturation, optional binarisation
  // --------------------------------------------------------------------------
  function automatic logic [10:0] abs11(input logic [10:0] v);
    return v[10] ? (~v + 11'd1) : v;
  endfunction

  logic [10:0] mag;
  logic [7:0]  sat;
  logic [7:0]  pix;

  // |Gx|+|Gy| peaks at 2040, which still fits 11 unsigned bits.
  assign mag = abs11(gx) + abs11(gy);
  assign sat = (mag > 11'd255) ? 8'hFF : mag[7:0];

`ifdef SOBEL_THRESHOLD_EN
  assign pix = (sat >= THRESHOLD) ? 8'd255 : 8'd0;
`else
  assign pix = sat;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o <= 1'b0;
      data_o  <= 8'd0;
      done_o  <= 1'b0;
    end else begin
      valid_o <= s2_valid;
      data_o  <= pix;
      done_o  <= s2_valid && s2_last;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sobel_gradient_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_sobel_gradient_stage
//  Purpose  : Directed self-checking bench for sobel_gradient_stage using
//             hand-computed expected pixels for 5x5 frames.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_gradient_stage;

  localparam int         W   = 5;
  localparam int         H   = 5;
  localparam logic [7:0] THR = 8'd50;

  logic       clk     = 1'b0;
  logic       rst     = 1'b0;
  logic       valid_i = 1'b0;
  logic [7:0] data0_i = 8'd0;
  logic [7:0] data1_i = 8'd0;
  logic [7:0] data2_i = 8'd0;
  logic       valid_o;
  logic [7:0] data_o;
  logic       done_o;

  always #5 clk = ~clk;

  sobel_gradient_stage #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .THRESHOLD (THR)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .valid_i(valid_i),
    .data0_i(data0_i),
    .data1_i(data1_i),
    .data2_i(data2_i),
    .valid_o(valid_o),
    .data_o (data_o),
    .done_o (done_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected output stream
  int exp_q[$];
  bit done_q[$];
  int out_count  = 0;
  int done_count = 0;
  int b2b_count  = 0;
  bit prev_valid = 1'b0;
  int ev;
  bit ed;

  // Map a saturated magnitude to the value data_o should carry.
  function automatic int xf(input int mag);
`ifdef SOBEL_THRESHOLD_EN
    return (mag >= THR) ? 255 : 0;
`else
    return mag;
`endif
  endfunction

  // Output monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (valid_o) begin
        out_count++;
        if (prev_valid) b2b_count++;
        if (done_o) done_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_output", valid_o, 0);
        end else begin
          ev = exp_q.pop_front();
          ed = done_q.pop_front();
          check("data_o", data_o, ev);
          check("done_o", done_o, ed);
        end
      end else if (done_o) begin
        check("done_without_valid", done_o, 0);
      end
      prev_valid = valid_o;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Called at a falling edge; returns at a falling edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input int gap);
    valid_i = 1'b1;
    data0_i = a;
    data1_i = b;
    data2_i = c;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Every triplet row of a frame uses the same column pattern.
  task automatic send_frame(input logic [7:0] top [W], input logic [7:0] mid [W],
                            input logic [7:0] bot [W], input int gap);
    for (int r = 0; r < H - 2; r++) begin
      for (int c = 0; c < W; c++) begin
        send(top[c], mid[c], bot[c], gap);
      end
    end
  endtask

  task automatic expect_frame(input int v0, input int v1, input int v2);
    for (int r = 0; r < H - 2; r++) begin
      exp_q.push_back(xf(v0)); done_q.push_back(1'b0);
      exp_q.push_back(xf(v1)); done_q.push_back(1'b0);
      exp_q.push_back(xf(v2)); done_q.push_back(r == H - 3);
    end
  endtask

  task automatic clear_counts();
    out_count  = 0;
    done_count = 0;
    b2b_count  = 0;
  endtask

  task automatic finish_test(input string name, input int n_out, input int n_done);
    repeat (6) @(negedge clk);
    check({name, "_outputs"}, out_count, n_out);
    check({name, "_done_pulses"}, done_count, n_done);
    check({name, "_pending"}, exp_q.size(), 0);
  endtask

  logic [7:0] flat [W]  = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
  logic [7:0] vedge [W] = '{8'd0, 8'd0, 8'd255, 8'd255, 8'd255};
  logic [7:0] ramp [W]  = '{8'd0, 8'd10, 8'd20, 8'd30, 8'd40};
  logic [7:0] zero [W]  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  logic [7:0] thirty [W] = '{8'd30, 8'd30, 8'd30, 8'd30, 8'd30};

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_valid_o", valid_o, 0);
    check("reset_data_o", data_o, 0);
    check("reset_done_o", done_o, 0);
    rst = 1'b1;
    @(negedge clk);

    // Flat field: all zero gradients, outputs back-to-back within a row
    clear_counts();
    expect_frame(0, 0, 0);
    send_frame(flat, flat, flat, 0);
    finish_test("flat", 9, 1);
    check("flat_b2b_pairs", b2b_count, 6);

    // Vertical edge: Gx = 1020 saturates
    clear_counts();
    expect_frame(255, 255, 0);
    send_frame(vedge, vedge, vedge, 0);
    finish_test("vedge", 9, 1);

    // Ramp: Gx = 4*20 = 80
    clear_counts();
    expect_frame(80, 80, 80);
    send_frame(ramp, ramp, ramp, 0);
    finish_test("ramp", 9, 1);

    // Horizontal gradient: Gy = 4*30 = 120
    clear_counts();
    expect_frame(120, 120, 120);
    send_frame(zero, zero, thirty, 0);
    finish_test("hgrad", 9, 1);

    // Same with 2-cycle gaps: no two outputs adjacent
    clear_counts();
    expect_frame(120, 120, 120);
    send_frame(zero, zero, thirty, 2);
    finish_test("hgrad_gap", 9, 1);
    check("hgrad_gap_b2b_pairs", b2b_count, 0);

    // Reset mid-row: row 0 complete, row 1 columns 0..3
    clear_counts();
    exp_q.push_back(xf(255)); done_q.push_back(1'b0);
    exp_q.push_back(xf(255)); done_q.push_back(1'b0);
    exp_q.push_back(xf(0));   done_q.push_back(1'b0);
    for (int c = 0; c < W; c++) send(vedge[c], vedge[c], vedge[c], 0);
    for (int c = 0; c < 4; c++) send(vedge[c], vedge[c], vedge[c], 0);
    // Row 1 column 2 result is on the outputs after the next rising edge.
    @(posedge clk);
    #2;
    check("pre_reset_valid_o", valid_o, 1);
    check("pre_reset_data_o", data_o, xf(255));
    rst = 1'b0;
    #1;
    check("async_reset_valid_o", valid_o, 0);
    check("async_reset_data_o", data_o, 0);
    check("async_reset_done_o", done_o, 0);
    check("mid_reset_outputs_before", out_count, 3);
    exp_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_counts();
    expect_frame(80, 80, 80);
    send_frame(ramp, ramp, ramp, 0);
    finish_test("after_reset", 9, 1);

    // Back-to-back frames with no bubble
    clear_counts();
    expect_frame(80, 80, 80);
    expect_frame(255, 255, 0);
    send_frame(ramp, ramp, ramp, 0);
    send_frame(vedge, vedge, vedge, 0);
    finish_test("b2b_frames", 18, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sobel_gradient_stage.md
# sobel_gradient_stage

Consumes the three vertically aligned pixel columns produced by `fifo_double_line_buffer` (`data0_o`/`data1_o`/`data2_o`, one column per `we_i` cycle), forms a sliding 3x3 window and computes the Sobel gradient magnitude |Gx|+|Gy|, saturated to 8 bits. It is a 3-stage pipeline with valid tracking, per-row edge suppression and a frame-done pulse. It sits directly downstream of the double line buffer and feeds the output pixel sink.

## Interface
Parameters:
- `IMG_WIDTH`, 5: pixels per row; minimum 3.
- `IMG_HEIGHT`, 5: rows per frame; minimum 3.
- `THRESHOLD`, 8'd64: binarisation threshold; used only with `SOBEL_THRESHOLD_EN`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `valid_i`  in  1  column triplet valid; connect to the line buffer write enable.
- `data0_i`  in  8  pixel from row y-2 (oldest).
- `data1_i`  in  8  pixel from row y-1.
- `data2_i`  in  8  pixel from row y (newest).
- `valid_o`  out  1  `data_o` holds a gradient pixel.
- `data_o`  out  8  gradient magnitude, or binary 0/255 with the macro.
- `done_o`  out  1  one-cycle pulse on the last output pixel of a frame.

## Operation
- Window: 3x3 registers p[r][c]. Row r=0 is data0, r=2 is data2; column c=2 is newest. On each `valid_i`, columns shift left and the new triplet loads into c=2. With `valid_i` low the window holds.
- Column counter `col` runs 0..IMG_WIDTH-1. It increments on each accepted triplet and wraps to 0 after IMG_WIDTH-1. A window is complete when the accepted triplet has `col` >= 2. This gives IMG_WIDTH-2 outputs per row. No window spans two rows.
- Row counter `row` runs 0..IMG_HEIGHT-3 and increments on column wrap. The last column of the last row marks end of frame; both counters then return to 0.
- Gx = (p02+2p12+p22) − (p00+2p10+p20).
- Gy = (p20+2p21+p22) − (p00+2p01+p02).
- Gx and Gy are 11-bit signed, range ±1020. Magnitude |Gx|+|Gy| is 11-bit unsigned, max 2040. `data_o` = min(magnitude, 255).
- Pipeline: S1 window plus complete/last flags; S2 Gx/Gy registered; S3 saturated magnitude, `valid_o`, `done_o` registered. S2 and S3 advance every cycle regardless of `valid_i`; valid bits travel with the data.

## Timing
- Reset values: `valid_o`=0, `data_o`=0, `done_o`=0; window, counters and pipeline registers all 0.
- Latency: a triplet completing a window is sampled at edge k. `valid_o`/`data_o` are valid during the cycle after edge k+2.
- Throughput: one pixel per cycle. Back-to-back and gapped `valid_i` are both legal. Gaps produce matching gaps in `valid_o`; windowing is unaffected.
- `done_o` rises in the same cycle as the final `valid_o` of the frame, for exactly one cycle.
- There is no backpressure; the downstream stage must accept every `valid_o`.
- Reset asserted mid-row or mid-frame clears everything immediately. In-flight results are discarded. The next accepted triplet is column 0 of row 0.
- A new frame may start the cycle after the last triplet of the previous frame; counter wrap handles this with no bubble.

## Configuration
- `SOBEL_THRESHOLD_EN` defined: S3 outputs 8'd255 if saturated magnitude >= THRESHOLD, else 8'd0. Latency is unchanged.
- Not defined: S3 outputs the saturated magnitude. The `THRESHOLD` parameter is ignored.

## Test plan
- Flat field: every triplet 100/100/100, 5x5 frame → 9 `valid_o` pulses, all `data_o`=0. `done_o` pulses once, with the 9th output.
- Vertical edge: each row's columns 0,0,255,255,255 in all three rows → per row `data_o` = 255, 255, 0 (Gx=1020 saturates).
- Ramp: columns 0,10,20,30,40 in all rows → each output 80 (Gx=80, Gy=0). With `SOBEL_THRESHOLD_EN` and THRESHOLD=50 → 255 each.
- Horizontal gradient: triplets 0/0/30 every column → each output 120 (Gy=120). Insert 2-cycle `valid_i` gaps between columns → identical values, gapped `valid_o`, same pulse count.
- Reset mid-row: deassert `rst` after column 3 of row 1 → outputs go to 0 asynchronously. A fresh full frame then yields exactly 9 outputs and one `done_o`.
- Back-to-back frames: two 5x5 frames with no gap → 18 outputs, and `done_o` pulses at outputs 9 and 18.
